// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: byte FIFO feeding an 8N1 serialiser (8E1 when
// UART_TX_PARITY_EN is defined), with back-to-back frames and no idle gap.
module uart_tx_buffered #(
    parameter int unsigned CLKS_PER_BIT = 10417,
    parameter int unsigned FIFO_DEPTH   = 16,
    parameter int unsigned ADDR_W       = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [7:0]        wr_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              tx_line,
    output logic              tx_active,
    output logic              tx_done
);

    localparam int unsigned PTR_W  = ADDR_W + 1;
    localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t              state_q, state_d;
    logic [BAUD_W-1:0]   baud_q, baud_d;
    logic [2:0]          bit_idx_q, bit_idx_d;
    logic [7:0]          data_q, data_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]    count_q, count_d;
    logic                full_q, full_d;
    logic                empty_q, empty_d;
    logic                tx_line_q, tx_line_d;
    logic                tx_active_q, tx_active_d;
    logic                tx_done_q, tx_done_d;
    logic [7:0]          mem_q [FIFO_DEPTH];
    logic                push_c;
    logic                pop_c;
    logic                bit_end_c;
    logic [7:0]          head_c;

    assign push_c    = wr_en && !full_q;
    assign bit_end_c = (baud_q == BAUD_LAST);
    assign head_c    = mem_q[rd_ptr_q[ADDR_W-1:0]];

    // FIFO pointer bookkeeping; the extra MSB separates full from empty
    always_comb begin
        wr_ptr_d = push_c ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop_c  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = wr_ptr_d - rd_ptr_d;
        empty_d  = (wr_ptr_d == rd_ptr_d);
        full_d   = (wr_ptr_d[ADDR_W] != rd_ptr_d[ADDR_W]) &&
                   (wr_ptr_d[ADDR_W-1:0] == rd_ptr_d[ADDR_W-1:0]);
    end

    // Frame sequencer; outputs are decoded from the next state and registered
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        data_d    = data_q;
        pop_c     = 1'b0;

        if (state_q != IDLE) begin
            baud_d = bit_end_c ? '0 : baud_q + BAUD_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (!empty_q) begin
                    pop_c     = 1'b1;
                    data_d    = head_c;
                    bit_idx_d = '0;
                    baud_d    = '0;
                    state_d   = START;
                end
            end
            START: begin
                if (bit_end_c) state_d = DATA;
            end
            DATA: begin
                if (bit_end_c) begin
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end_c) state_d = STOP;
            end
`endif
            STOP: begin
                if (bit_end_c) begin
                    if (!empty_q) begin
                        pop_c     = 1'b1;
                        data_d    = head_c;
                        bit_idx_d = '0;
                        state_d   = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        tx_line_d = 1'b1;
        case (state_d)
            START:   tx_line_d = 1'b0;
            DATA:    tx_line_d = data_d[bit_idx_d];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_line_d = ^data_d;
`endif
            default: tx_line_d = 1'b1;
        endcase
        tx_active_d = (state_d != IDLE);
        tx_done_d   = (state_d == STOP) && (baud_d == BAUD_LAST);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            baud_q      <= '0;
            bit_idx_q   <= '0;
            data_q      <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            tx_line_q   <= 1'b1;
            tx_active_q <= 1'b0;
            tx_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            baud_q      <= baud_d;
            bit_idx_q   <= bit_idx_d;
            data_q      <= data_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            tx_line_q   <= tx_line_d;
            tx_active_q <= tx_active_d;
            tx_done_q   <= tx_done_d;
        end
    end

    // Storage needs no reset: pointers define which entries are valid
    always_ff @(posedge clk) begin
        if (push_c && !reset) begin
            mem_q[wr_ptr_q[ADDR_W-1:0]] <= wr_data;
        end
    end

    assign full      = full_q;
    assign empty     = empty_q;
    assign count     = count_q;
    assign tx_line   = tx_line_q;
    assign tx_active = tx_active_q;
    assign tx_done   = tx_done_q;

endmodule
